// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one sequential FP multiplier between NREQ requesters.
module fp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] a_in,
  input  logic [NREQ*32-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [31:0]       result,
  output logic              err,
  output logic              busy,
  output logic              fp_start,
  output logic [31:0]       fp_a,
  output logic [31:0]       fp_b,
  input  logic              fp_done,
  input  logic [31:0]       fp_result
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAITLO, WAITHI} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, gnt_id, win, idx;
  logic [NREQ-1:0] gnt_oh;
  logic [31:0] op_a, op_b;
  logic [31:0] a_sl [NREQ];
  logic [31:0] b_sl [NREQ];
  logic [7:0] cnt;
  logic found, grant, timeout, complete;
  for (genvar g = 0; g < NREQ; g++) begin : g_sl
    assign a_sl[g] = a_in[32*g +: 32];
    assign b_sl[g] = b_in[32*g +: 32];
  end
  // first requester after the last one served, wrapping around
  always_comb begin
    win = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign grant    = state == IDLE && found && fp_done;
  assign timeout  = (state == WAITLO || state == WAITHI) && cnt == 8'(TIMEOUT);
  assign complete = state == WAITHI && fp_done;
  assign gnt_oh   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
  assign ack      = (state == ISSUE) ? gnt_oh : '0;
  assign fp_start = state == ISSUE;
  assign busy     = state != IDLE;
  assign fp_a     = op_a;
  assign fp_b     = op_b;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = grant ? ISSUE : IDLE;
      ISSUE:   state_n = WAITLO;
      WAITLO:  state_n = timeout ? IDLE : (fp_done ? WAITLO : WAITHI);
      WAITHI:  state_n = (complete || timeout) ? IDLE : WAITHI;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      gnt_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      err    <= 1'b0;
      done   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      done  <= '0;
      err   <= 1'b0;
      cnt   <= (state == ISSUE) ? '0 : (state == WAITLO || state == WAITHI) ? cnt + 8'd1 : cnt;
      if (grant) begin
        gnt_id <= win;
        op_a   <= a_sl[win];
        op_b   <= b_sl[win];
      end
      // a completion seen in the same cycle as the deadline still counts as good
      if (complete || timeout) begin
        result <= complete ? fp_result : 32'h7FC00000;
        err    <= !complete;
        done   <= gnt_oh;
        ptr    <= gnt_id;
      end
    end
  end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter that shares one sequential single-precision FP multiplier between NREQ requesters. It latches the winning requester's operands and sequences the multiplier's start/done handshake. It returns the 32-bit product with a one-cycle done pulse tagged to the originating requester. It sits between the requester ports and the multiplier's startFP/Abus/Bbus/Outbus/doneFP pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 63, max cycles from issue to multiplier completion before abort (≤255)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; same net also resets the multiplier
- req  in  NREQ  level request per requester; sampled only in IDLE
- a_in  in  NREQ*32  packed operand A, slice i = a_in[32i+31:32i]
- b_in  in  NREQ*32  packed operand B, same packing
- ack  out  NREQ  one-hot, one-cycle pulse: operands of requester i accepted
- done  out  NREQ  one-hot, one-cycle pulse: result for requester i valid
- result  out  32  product; held until next completion
- err  out  1  high together with done when the operation timed out
- busy  out  1  high in every state except IDLE
- fp_start  out  1  to multiplier startFP
- fp_a, fp_b  out  32 each  to multiplier Abus/Bbus
- fp_done  in  1  multiplier doneFP (high = idle)
- fp_result  in  32  multiplier Outbus

## Operation
- Registers: state, ptr (last granted index), gnt_id, op_a, op_b, result, err, done, cnt (8 bits).
- fp_a/fp_b = op_a/op_b at all times. Multiplier exponent path is combinational on its inputs, so op_a/op_b must stay stable from ISSUE until capture.
- IDLE: if any req and fp_done==1 → select winner. Search order: ptr+1, ptr+2, …, wrapping modulo NREQ. Latch op_a/op_b from the winner's slices, set gnt_id, go to ISSUE. If fp_done==0, grant nothing.
- ISSUE (1 cycle): fp_start=1; ack[gnt_id]=1; cnt←0; go to WAITLO.
- WAITLO: cnt++ each cycle. When fp_done==0 → WAITHI.
- WAITHI: cnt++ each cycle. When fp_done==1 → result←fp_result, err←0, done[gnt_id]←1 (next cycle), ptr←gnt_id, go to IDLE.
- Timeout: if cnt==TIMEOUT in WAITLO or WAITHI → result←32'h7FC00000, err←1, done[gnt_id]←1, ptr←gnt_id, go to IDLE.
- ack and fp_start are decoded from state==ISSUE. done and err are registered pulses, cleared the following cycle. result is not cleared.
- Requester contract: hold req and operands until ack. Requester i must drop req in the ack cycle unless it has a further operation. After ack, operands may change.
- Any other state encoding → IDLE.

## Timing
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 first), ack=0, done=0, err=0, result=0, fp_start=0, busy=0, op_a=op_b=0, cnt=0.
- Grant latency: req seen in IDLE at cycle t → ISSUE/ack at t+1.
- Completion: done appears 1 cycle after fp_done rises in WAITHI. Nominal end-to-end is ~32 cycles; correctness must not depend on the exact count.
- Back-to-back: IDLE is re-entered in the done cycle, so the next grant's ack is at done+1 at the earliest.
- At most one operation is outstanding; no queueing. Losers keep req high and are served in rotation; starvation is bounded by NREQ operations.
- Simultaneous req from all requesters: grants proceed in rotation from ptr+1.
- A request arriving while busy is ignored until IDLE, with no loss as long as req is held.
- rst mid-operation: next cycle all outputs take reset values, with no done for the in-flight op. Multiplier is reset concurrently.

## Test plan
- Single op: req[0], a=0x40400000 (3.0), b=0x40000000 (2.0) → ack[0] one cycle after req; done[0] pulse, result=0x40C00000, err=0.
- Sign: req[2], a=0xBFC00000 (-1.5), b=0x40000000 → done[2], result=0xC0400000.
- Fairness: req=4'b1111 held with distinct operands → ack order 0,1,2,3,0; each done carries that requester's product.
- Rotation after partial service: grant 2, then req=4'b0101 → next grant 0 (wraps past 3).
- Timeout: model holds fp_done=0 → done[gnt_id], err=1, result=0x7FC00000 at cnt==TIMEOUT; next request then served normally.
- Reset mid-op: assert rst during WAITHI → no done; busy=0, ptr=3 next cycle; a following req[1] is granted ahead of req[2].
